rv32_mul_div_unit: RTL and testbench
====================================

Name: rv32_mul_div_unit

Overview:
Iterative RV32M execution unit for MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. The unit sits beside the Execute stage and takes an operation when Execute issues it. While the operation runs it reports its busy status, destination register and source registers to the hazard unit. On completion it presents a one-cycle result with a done strobe, and the Writeback mux consumes that result. The hazard unit uses running/done to stall the pipeline, and it can abort the in-flight operation through a flush.

Parameters:
XLEN, 32, operand and result width
ITER_CYCLES, 32, BUSY cycles per normal multiply or divide (one bit per cycle)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_n_i  in  1  reset, asynchronous, active-low
start_i  in  1  issue request from Execute
op_i  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a_i  in  XLEN  rs1 operand, already forwarded
b_i  in  XLEN  rs2 operand, already forwarded
rd_i  in  5  destination register of the issued op
rs1_i, rs2_i  in  5  source register indices of the issued op
flush_i  in  1  abort the in-flight op (driven by the hazard unit's md flush)
running_o  out  1  op in BUSY state
done_o  out  1  result valid, single-cycle strobe
result_o  out  XLEN  final result, meaningful only when done_o=1
rd_o  out  5  destination of the in-flight/completing op
rs1_o, rs2_o  out  5  sources of the in-flight op

Behaviour:
- Reset (asynchronous, any state): state=IDLE; running_o=0, done_o=0; result_o=0; rd_o, rs1_o, rs2_o = 0; all datapath registers = 0. Reset mid-operation discards the op and produces no done_o.
- FSM states: IDLE, BUSY, DONE.
- IDLE, start_i=1, flush_i=0:
  - Latch op, rd, rs1, rs2 and the operands.
  - Signed ops (MULH, and DIV/REM) convert both operands to magnitudes. MULHSU converts only a_i.
  - Record the result sign: product sign = sign(a) XOR sign(b). Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
  - Load counter = ITER_CYCLES and go to BUSY, unless a fast path applies.
- Fast paths: IDLE goes straight to DONE, so done_o is asserted in the cycle after the start edge.
  - b=0, DIV/DIVU: result = 0xFFFFFFFF.
  - b=0, REM/REMU: result = a.
  - Signed overflow, a=0x80000000 and b=0xFFFFFFFF: DIV result = 0x80000000; REM result = 0.
- BUSY:
  - Multiply: one shift-add step per cycle into a 2*XLEN accumulator.
  - Divide: one restoring-division step per cycle, with quotient and remainder in XLEN registers.
  - The counter decrements each cycle. When the counter reaches 1, the next edge goes to DONE, giving exactly ITER_CYCLES BUSY cycles.
  - running_o=1 throughout BUSY.
- DONE:
  - done_o=1 and running_o=0 for exactly one cycle; result_o is valid; rd_o is held.
  - Result selection:
    - MUL: low half of the product.
    - MULH/MULHSU/MULHU: high half of the product.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Apply sign correction (two's-complement negate when the recorded sign is 1) for signed ops only.
  - Next edge returns to IDLE unconditionally.
- Latency: start edge E0; for normal ops done_o is high in the cycle after edge E0+ITER_CYCLES (33 cycles). Throughput is one op per ITER_CYCLES+2 cycles.
- start_i while BUSY or DONE: ignored, and latched fields do not change.
- start_i in the DONE cycle: ignored. Execute must re-issue, and the hazard stall (driven by done_o) guarantees this.
- flush_i=1 in BUSY: next edge goes to IDLE; running_o drops and no done_o is produced. rd_o, rs1_o, rs2_o clear to 0.
- flush_i=1 in IDLE together with start_i: flush wins and nothing is latched.
- flush_i in DONE: ignored, because the result is already committed.
- rd_o, rs1_o, rs2_o are 0 in IDLE. An x0 destination still runs the full latency; writeback suppression is done downstream.
- All arithmetic is unsigned on magnitudes. The product is exactly 64 bits, with no truncation before selection.

Decomposition:
- rv32_pkg additions:
  - md_op_e enum with the funct3 encodings above.
  - md_state_e (IDLE/BUSY/DONE).
  - MD_ITER_CYCLES constant.
  - Constant DIV_BY_ZERO_Q = all ones.
- Sub-module rv32_div_core: the restoring-division datapath with load/step inputs and quotient/remainder outputs, reused by the multiplier's shift logic only if that is convenient.
- The FSM, sign handling and the multiplier stay in rv32_mul_div_unit.

Test Plan:
- MUL: a=7, b=-3 (0xFFFFFFFD), start -> done_o exactly 33 cycles later; result 0xFFFFFFEB. Repeat as MULH -> 0xFFFFFFFF; as MULHU -> 0x00000006.
- DIV: a=-20, b=3 -> done at 33 cycles; result 0xFFFFFFFA. REM with the same operands -> 0xFFFFFFFE. DIVU a=20, b=3 -> 6.
- Fast paths:
  - DIVU a=5, b=0 -> done_o in the cycle after start; result 0xFFFFFFFF.
  - REM a=5, b=0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; the matching REM -> 0.
- Start at cycle 0, flush_i pulse at cycle 10 -> running_o=0 from cycle 11; done_o never asserts; a new start at cycle 12 completes normally.
- Assert rst_n_i low mid-BUSY -> all outputs 0 immediately (asynchronous); no done_o after release.
- start_i held high for 40 cycles -> exactly one completion at cycle 33; second op accepted at cycle 34 (IDLE); running_o/rd_o track the hazard-unit view.

Source files
------------

// File: rtl/rv32_mul_div_unit_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
// Holds the funct3 operation encodings, FSM state encodings and iteration count.
// Also provides small decode helpers for operand signedness.
package rv32_mul_div_unit_pkg;

    localparam int MD_XLEN        = 32;
    localparam int MD_ITER_CYCLES = 32;

    // Quotient returned for any division by zero.
    localparam logic [MD_XLEN-1:0] DIV_BY_ZERO_Q = '1;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic md_a_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM (MULHSU keeps rs2 unsigned).
    function automatic logic md_b_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/rv32_mul_div_unit_if.sv
// Issue/result bundle between Execute + hazard unit (master) and the md unit (slave).
// Latency: none, pure wiring.
// Backpressure: none; the hazard unit stalls on running_o/done_o.
// Ports: start/op/operands/register indices/flush in; running/done/result/indices out.
interface rv32_mul_div_unit_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic [4:0]      rd_i;
    logic [4:0]      rs1_i;
    logic [4:0]      rs2_i;
    logic            flush_i;
    logic            running_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_o;
    logic [4:0]      rs1_o;
    logic [4:0]      rs2_o;

    modport master (
        output start_i, op_i, a_i, b_i, rd_i, rs1_i, rs2_i, flush_i,
        input  running_o, done_o, result_o, rd_o, rs1_o, rs2_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, rd_i, rs1_i, rs2_i, flush_i,
        output running_o, done_o, result_o, rd_o, rs1_o, rs2_o
    );

endinterface

// File: rtl/rv32_mul_div_unit_div_core.sv
// Restoring unsigned divider datapath: one quotient bit per step_i pulse.
// Latency: XLEN step pulses after load_i for a full quotient/remainder.
// Backpressure: none; the owning FSM decides when to load and step.
// Ports: clk_i/rst_n_i, load_i with dividend_i/divisor_i, step_i; quot_o/rem_o.
module rv32_mul_div_unit_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quot_o,
    output logic [XLEN-1:0] rem_o
);

    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;

    logic [XLEN:0]   rem_shift;
    logic            fits;
    logic [XLEN-1:0] rem_sub;

    // The dividend shifts out of quot_q MSB-first while quotient bits shift in.
    // The partial remainder is always below the divisor, so the subtraction
    // result fits in XLEN bits whenever it is kept.
    always_comb begin
        rem_shift = {rem_q, quot_q[XLEN-1]};
        fits      = rem_shift >= {1'b0, dvsr_q};
        rem_sub   = rem_shift[XLEN-1:0] - dvsr_q;

        quot_d = quot_q;
        rem_d  = rem_q;
        dvsr_d = dvsr_q;
        if (load_i) begin
            quot_d = dividend_i;
            rem_d  = '0;
            dvsr_d = divisor_i;
        end else if (step_i) begin
            quot_d = {quot_q[XLEN-2:0], fits};
            rem_d  = fits ? rem_sub : rem_shift[XLEN-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            quot_q <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
        end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dvsr_q <= dvsr_d;
        end
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/rv32_mul_div_unit.sv
// RV32M iterative multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Latency: ITER_CYCLES+1 cycles to done_o; div-by-zero and signed overflow finish next cycle.
// Backpressure: none; start_i outside IDLE is ignored, hazard unit stalls on running_o/done_o.
// Ports: clk_i, rst_n_i (async active-low), md (slave side of rv32_mul_div_unit_if).
module rv32_mul_div_unit
    import rv32_mul_div_unit_pkg::*;
#(
    parameter int XLEN        = MD_XLEN,
    parameter int ITER_CYCLES = MD_ITER_CYCLES
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    rv32_mul_div_unit_if.slave md
);

    localparam int            CW       = $clog2(ITER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(ITER_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    localparam logic [1:0] S_IDLE = MD_IDLE;
    localparam logic [1:0] S_BUSY = MD_BUSY;
    localparam logic [1:0] S_DONE = MD_DONE;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [4:0]        rs1_q, rs1_d;
    logic [4:0]        rs2_q, rs2_d;
    logic              neg_q, neg_d;
    logic              fast_q, fast_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;

    // Issue-side decode.
    logic            accept;
    logic            in_div;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            res_neg_in;
    logic            b_zero, ovf, fast_in;
    logic [XLEN-1:0] fast_res;

    // Multiplier step.
    logic [XLEN-1:0]   mul_addend;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] acc_step;

    // Divider and result selection.
    logic              div_step;
    logic [XLEN-1:0]   quot, rem;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, res_sel;

    always_comb begin
        accept  = (state_q == S_IDLE) && md.start_i && !md.flush_i;
        in_div  = md.op_i[2];
        a_neg   = md_a_signed(md.op_i) && md.a_i[XLEN-1];
        b_neg   = md_b_signed(md.op_i) && md.b_i[XLEN-1];
        a_mag   = a_neg ? -md.a_i : md.a_i;
        b_mag   = b_neg ? -md.b_i : md.b_i;
        // Remainder takes the dividend's sign; everything else is sign(a)^sign(b).
        // Unsigned forms never set either flag, so they never get negated.
        res_neg_in = (md.op_i == MD_REM) ? a_neg : (a_neg ^ b_neg);

        b_zero  = (md.b_i == '0);
        ovf     = ((md.op_i == MD_DIV) || (md.op_i == MD_REM)) &&
                  (md.a_i == MIN_NEG) && (md.b_i == '1);
        fast_in = in_div && (b_zero || ovf);
        // op[1] separates REM* from DIV*. Overflow quotient equals a (MIN_NEG).
        if (b_zero) begin
            fast_res = md.op_i[1] ? md.a_i : XLEN'(DIV_BY_ZERO_Q);
        end else begin
            fast_res = md.op_i[1] ? '0 : md.a_i;
        end
    end

    // Shift-add: the multiplier sits in the low half of acc and is consumed
    // from bit 0 while partial sums enter from the top with their carry.
    always_comb begin
        mul_addend = acc_q[0] ? mcand_q : '0;
        mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
        acc_step   = {mul_sum, acc_q[XLEN-1:1]};
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        neg_d   = neg_q;
        fast_d  = fast_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = md.op_i;
                    rd_d   = md.rd_i;
                    rs1_d  = md.rs1_i;
                    rs2_d  = md.rs2_i;
                    neg_d  = res_neg_in;
                    fast_d = fast_in;
                    if (fast_in) begin
                        // Fast result parks in the low half of acc.
                        acc_d   = {{XLEN{1'b0}}, fast_res};
                        state_d = S_DONE;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, b_mag};
                        mcand_d = a_mag;
                        cnt_d   = CNT_LOAD;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (md.flush_i) begin
                    state_d = S_IDLE;
                    rd_d    = '0;
                    rs1_d   = '0;
                    rs2_d   = '0;
                end else begin
                    if (!op_q[2]) begin
                        acc_d = acc_step;
                    end
                    cnt_d = cnt_q - CNT_LAST;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Result is committed here; flush has no effect.
                state_d = S_IDLE;
                rd_d    = '0;
                rs1_d   = '0;
                rs2_d   = '0;
                neg_d   = 1'b0;
                fast_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            neg_q   <= 1'b0;
            fast_q  <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            neg_q   <= neg_d;
            fast_q  <= fast_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
        end
    end

    assign div_step = (state_q == S_BUSY) && op_q[2] && !md.flush_i;

    rv32_mul_div_unit_div_core #(
        .XLEN (XLEN)
    ) u_div_core (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (accept),
        .step_i     (div_step),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .quot_o     (quot),
        .rem_o      (rem)
    );

    // The product must be negated as a full 2*XLEN value before the high
    // half is taken; negating only the high half would be off by a borrow.
    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quot_fix = neg_q ? -quot : quot;
        rem_fix  = neg_q ? -rem : rem;
        res_sel  = '0;
        if (fast_q) begin
            res_sel = acc_q[XLEN-1:0];
        end else begin
            case (op_q)
                MD_MUL:                       res_sel = prod_fix[XLEN-1:0];
                MD_MULH, MD_MULHSU, MD_MULHU: res_sel = prod_fix[2*XLEN-1:XLEN];
                MD_DIV, MD_DIVU:              res_sel = quot_fix;
                default:                      res_sel = rem_fix;
            endcase
        end
    end

    assign md.running_o = (state_q == S_BUSY);
    assign md.done_o    = (state_q == S_DONE);
    assign md.result_o  = (state_q == S_DONE) ? res_sel : '0;
    assign md.rd_o      = rd_q;
    assign md.rs1_o     = rs1_q;
    assign md.rs2_o     = rs2_q;

endmodule

// File: tb/tb_rv32_mul_div_unit.sv
// Self-checking bench for rv32_mul_div_unit: scoreboard of expected results
// popped on done_o, plus per-scenario latency/flush/reset/hazard-view checks.
// Cycle numbering: the cycle in which start_i is driven is cycle 0.
module tb_rv32_mul_div_unit;
    import rv32_mul_div_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rv32_mul_div_unit_if #(.XLEN(32)) md_if();

    rv32_mul_div_unit #(
        .XLEN        (32),
        .ITER_CYCLES (32)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .md      (md_if.slave)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    exp_t scb[$];
    int tests_run    = 0;
    int tests_failed = 0;

    // Reference RV32M semantics, built on 64-bit arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0]        ua, ub, p;
        logic signed [31:0] qa, qb, qr;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        qa = a;
        qb = b;
        case (op)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * $signed(ub); return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                qr = qa / qb; return qr;
            end
            3'b101: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                qr = qa % qb; return qr;
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Scoreboard consumer: every done_o must match the oldest outstanding op.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && md_if.done_o === 1'b1) begin
            if (scb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_done: got result=%h rd=%0d, required no done_o", md_if.result_o, md_if.rd_o);
            end else begin
                e = scb.pop_front();
                tests_run++;
                if (md_if.result_o !== e.res) begin
                    tests_failed++;
                    $display("FAIL sb_result: got %h, required %h", md_if.result_o, e.res);
                end
                tests_run++;
                if (md_if.rd_o !== e.rd) begin
                    tests_failed++;
                    $display("FAIL sb_rd: got %0d, required %0d", md_if.rd_o, e.rd);
                end
                tests_run++;
                if (md_if.running_o !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL sb_running_in_done: got %b, required 0", md_if.running_o);
                end
            end
        end
    end

    task automatic drive_idle();
        md_if.start_i = 1'b0;
        md_if.flush_i = 1'b0;
        md_if.op_i    = 3'b000;
        md_if.a_i     = 32'd0;
        md_if.b_i     = 32'd0;
        md_if.rd_i    = 5'd0;
        md_if.rs1_i   = 5'd0;
        md_if.rs2_i   = 5'd0;
    endtask

    // Drives a one-cycle start (cycle 0) and returns in cycle 1.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] exp_res);
        @(negedge clk);
        md_if.op_i    = op;
        md_if.a_i     = a;
        md_if.b_i     = b;
        md_if.rd_i    = rd;
        md_if.rs1_i   = rs1;
        md_if.rs2_i   = rs2;
        md_if.start_i = 1'b1;
        scb.push_back('{exp_res, rd});
        @(negedge clk);
        md_if.start_i = 1'b0;
    endtask

    // Returns the cycle index (relative to the start cycle) of done_o, capped at 100.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (md_if.done_o !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        #1;
        tests_run++;
        if (md_if.running_o !== 1'b0 || md_if.done_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: running=%b done=%b, required 0 0", md_if.running_o, md_if.done_o);
        end
        tests_run++;
        if (md_if.result_o !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_result: got %h, required 0", md_if.result_o);
        end
        tests_run++;
        if (md_if.rd_o !== 5'd0 || md_if.rs1_o !== 5'd0 || md_if.rs2_o !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_regs: rd=%0d rs1=%0d rs2=%0d, required 0 0 0", md_if.rd_o, md_if.rs1_o, md_if.rs2_o);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        int lat;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 5'd1, 5'd2, 32'hFFFF_FFEB);
        tests_run++;
        if (md_if.running_o !== 1'b1 || md_if.rd_o !== 5'd5 || md_if.rs1_o !== 5'd1 || md_if.rs2_o !== 5'd2) begin
            tests_failed++;
            $display("FAIL mul_busy_view: running=%b rd=%0d rs1=%0d rs2=%0d, required 1 5 1 2",
                     md_if.running_o, md_if.rd_o, md_if.rs1_o, md_if.rs2_o);
        end
        wait_done(lat);
        tests_run++;
        if (lat !== 33) begin
            tests_failed++;
            $display("FAIL mul_latency: got %0d, required 33", lat);
        end
        @(negedge clk);
        tests_run++;
        if (md_if.running_o !== 1'b0 || md_if.done_o !== 1'b0 || md_if.rd_o !== 5'd0) begin
            tests_failed++;
            $display("FAIL mul_back_idle: running=%b done=%b rd=%0d, required 0 0 0",
                     md_if.running_o, md_if.done_o, md_if.rd_o);
        end
        issue(3'b001, 32'd7, 32'hFFFF_FFFD, 5'd6, 5'd1, 5'd2, 32'hFFFF_FFFF);
        wait_done(lat);
        tests_run++;
        if (lat !== 33) begin
            tests_failed++;
            $display("FAIL mulh_latency: got %0d, required 33", lat);
        end
        issue(3'b011, 32'd7, 32'hFFFF_FFFD, 5'd7, 5'd1, 5'd2, 32'h0000_0006);
        wait_done(lat);
        tests_run++;
        if (lat !== 33) begin
            tests_failed++;
            $display("FAIL mulhu_latency: got %0d, required 33", lat);
        end
    endtask

    task automatic test_div();
        int lat;
        issue(3'b100, 32'hFFFF_FFEC, 32'd3, 5'd10, 5'd3, 5'd4, 32'hFFFF_FFFA);
        wait_done(lat);
        tests_run++;
        if (lat !== 33) begin
            tests_failed++;
            $display("FAIL div_latency: got %0d, required 33", lat);
        end
        issue(3'b110, 32'hFFFF_FFEC, 32'd3, 5'd11, 5'd3, 5'd4, 32'hFFFF_FFFE);
        wait_done(lat);
        tests_run++;
        if (lat !== 33) begin
            tests_failed++;
            $display("FAIL rem_latency: got %0d, required 33", lat);
        end
        issue(3'b101, 32'd20, 32'd3, 5'd12, 5'd3, 5'd4, 32'd6);
        wait_done(lat);
        tests_run++;
        if (lat !== 33) begin
            tests_failed++;
            $display("FAIL divu_latency: got %0d, required 33", lat);
        end
    endtask

    task automatic test_fast_paths();
        int lat;
        issue(3'b101, 32'd5, 32'd0, 5'd13, 5'd0, 5'd0, 32'hFFFF_FFFF);
        wait_done(lat);
        tests_run++;
        if (lat !== 1) begin
            tests_failed++;
            $display("FAIL divu0_latency: got %0d, required 1", lat);
        end
        issue(3'b110, 32'd5, 32'd0, 5'd14, 5'd0, 5'd0, 32'd5);
        wait_done(lat);
        tests_run++;
        if (lat !== 1) begin
            tests_failed++;
            $display("FAIL rem0_latency: got %0d, required 1", lat);
        end
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 5'd0, 5'd0, 32'h8000_0000);
        wait_done(lat);
        tests_run++;
        if (lat !== 1) begin
            tests_failed++;
            $display("FAIL div_ovf_latency: got %0d, required 1", lat);
        end
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 5'd0, 5'd0, 32'd0);
        wait_done(lat);
        tests_run++;
        if (lat !== 1) begin
            tests_failed++;
            $display("FAIL rem_ovf_latency: got %0d, required 1", lat);
        end
        // Same operands unsigned: not an overflow case, full latency.
        issue(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 5'd0, 5'd0, 32'd0);
        wait_done(lat);
        tests_run++;
        if (lat !== 33) begin
            tests_failed++;
            $display("FAIL divu_big_latency: got %0d, required 33", lat);
        end
    endtask

    task automatic test_flush();
        int lat;
        issue(3'b000, 32'd1234, 32'd5678, 5'd3, 5'd8, 5'd9, 32'd0);
        for (int cyc = 2; cyc <= 10; cyc++) @(negedge clk);
        md_if.flush_i = 1'b1;
        @(negedge clk);
        md_if.flush_i = 1'b0;
        scb.delete();
        tests_run++;
        if (md_if.running_o !== 1'b0 || md_if.done_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_running: running=%b done=%b, required 0 0", md_if.running_o, md_if.done_o);
        end
        tests_run++;
        if (md_if.rd_o !== 5'd0 || md_if.rs1_o !== 5'd0 || md_if.rs2_o !== 5'd0) begin
            tests_failed++;
            $display("FAIL flush_regs: rd=%0d rs1=%0d rs2=%0d, required 0 0 0", md_if.rd_o, md_if.rs1_o, md_if.rs2_o);
        end
        issue(3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 5'd4, 5'd1, 5'd2, ref_md(3'b011, 32'hDEAD_BEEF, 32'h1234_5678));
        wait_done(lat);
        tests_run++;
        if (lat !== 33) begin
            tests_failed++;
            $display("FAIL flush_restart_latency: got %0d, required 33", lat);
        end
        // Flush together with start in IDLE: nothing is accepted.
        @(negedge clk);
        md_if.op_i    = 3'b000;
        md_if.rd_i    = 5'd9;
        md_if.start_i = 1'b1;
        md_if.flush_i = 1'b1;
        @(negedge clk);
        md_if.start_i = 1'b0;
        md_if.flush_i = 1'b0;
        tests_run++;
        if (md_if.running_o !== 1'b0 || md_if.done_o !== 1'b0 || md_if.rd_o !== 5'd0) begin
            tests_failed++;
            $display("FAIL flush_start_idle: running=%b done=%b rd=%0d, required 0 0 0",
                     md_if.running_o, md_if.done_o, md_if.rd_o);
        end
    endtask

    task automatic test_async_reset();
        int done_seen;
        issue(3'b100, 32'd1000, 32'd7, 5'd20, 5'd21, 5'd22, 32'd142);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        scb.delete();
        tests_run++;
        if (md_if.running_o !== 1'b0 || md_if.done_o !== 1'b0 || md_if.result_o !== 32'd0) begin
            tests_failed++;
            $display("FAIL areset_outputs: running=%b done=%b result=%h, required 0 0 0",
                     md_if.running_o, md_if.done_o, md_if.result_o);
        end
        tests_run++;
        if (md_if.rd_o !== 5'd0 || md_if.rs1_o !== 5'd0 || md_if.rs2_o !== 5'd0) begin
            tests_failed++;
            $display("FAIL areset_regs: rd=%0d rs1=%0d rs2=%0d, required 0 0 0", md_if.rd_o, md_if.rs1_o, md_if.rs2_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (md_if.done_o === 1'b1 || md_if.running_o === 1'b1) done_seen++;
        end
        tests_run++;
        if (done_seen !== 0) begin
            tests_failed++;
            $display("FAIL areset_no_done: activity cycles=%0d, required 0", done_seen);
        end
    endtask

    task automatic test_back_to_back();
        int done_cnt;
        int first_done;
        int lat;
        done_cnt   = 0;
        first_done = -1;
        @(negedge clk);
        md_if.op_i    = 3'b000;
        md_if.a_i     = 32'd3;
        md_if.b_i     = 32'd4;
        md_if.rd_i    = 5'd7;
        md_if.rs1_i   = 5'd3;
        md_if.rs2_i   = 5'd4;
        md_if.start_i = 1'b1;
        scb.push_back('{32'd12, 5'd7});
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 40) md_if.start_i = 1'b0;
            if (md_if.done_o === 1'b1) begin
                done_cnt++;
                if (first_done < 0) first_done = cyc;
            end
            if (cyc == 5) begin
                md_if.op_i  = 3'b101;
                md_if.a_i   = 32'd100;
                md_if.b_i   = 32'd7;
                md_if.rd_i  = 5'd8;
                md_if.rs1_i = 5'd11;
                md_if.rs2_i = 5'd12;
                scb.push_back('{32'd14, 5'd8});
            end
            if (cyc == 20) begin
                tests_run++;
                if (md_if.rd_o !== 5'd7 || md_if.rs1_o !== 5'd3 || md_if.rs2_o !== 5'd4 || md_if.running_o !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL b2b_latched: rd=%0d rs1=%0d rs2=%0d running=%b, required 7 3 4 1",
                             md_if.rd_o, md_if.rs1_o, md_if.rs2_o, md_if.running_o);
                end
            end
            if (cyc == 34) begin
                tests_run++;
                if (md_if.running_o !== 1'b0 || md_if.done_o !== 1'b0 || md_if.rd_o !== 5'd0) begin
                    tests_failed++;
                    $display("FAIL b2b_idle_gap: running=%b done=%b rd=%0d, required 0 0 0",
                             md_if.running_o, md_if.done_o, md_if.rd_o);
                end
            end
            if (cyc == 35) begin
                tests_run++;
                if (md_if.running_o !== 1'b1 || md_if.rd_o !== 5'd8 || md_if.rs1_o !== 5'd11) begin
                    tests_failed++;
                    $display("FAIL b2b_second_accept: running=%b rd=%0d rs1=%0d, required 1 8 11",
                             md_if.running_o, md_if.rd_o, md_if.rs1_o);
                end
            end
        end
        tests_run++;
        if (done_cnt !== 1 || first_done !== 33) begin
            tests_failed++;
            $display("FAIL b2b_first_done: count=%0d cycle=%0d, required 1 33", done_cnt, first_done);
        end
        wait_done(lat);
        tests_run++;
        if (40 + lat - 1 !== 67) begin
            tests_failed++;
            $display("FAIL b2b_second_done: cycle=%0d, required 67", 40 + lat - 1);
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [4:0]  rd;
        int          lat, want;
        logic        fast;
        for (int n = 0; n < 14; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom();
            b  = $urandom();
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            rd   = 5'($urandom_range(1, 31));
            fast = op[2] && ((b == 32'd0) ||
                   ((op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
            want = fast ? 1 : 33;
            issue(op, a, b, rd, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), ref_md(op, a, b));
            wait_done(lat);
            tests_run++;
            if (lat !== want) begin
                tests_failed++;
                $display("FAIL rand_latency op=%0d a=%h b=%h: got %0d, required %0d", op, a, b, lat, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_fast_paths();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random();
        repeat (3) @(negedge clk);
        tests_run++;
        if (scb.size() !== 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", scb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
